shared_delay_arbiter: RTL and testbench

- Shares one DEPTH-stage, WIDTH-bit register delay line between two requesters.
- Round-robin arbitration picks which requester enters stage 0 each cycle.
- A requester tag travels with the data, so each result is steered back to its owner.
- Adds valid/ready flow control with a global stall on back-pressure. It replaces bare register chains wherever two producers time-share a fixed-latency delay.

---
 rtl/shared_delay_arbiter.sv | 57 +++++
 tb/tb_shared_delay_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/shared_delay_arbiter.sv
// shared_delay_arbiter: two requesters share one DEPTH-stage delay line via round-robin;
// a tag rides with each word so the last stage is steered back to its owner.
module shared_delay_arbiter #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 3
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic [WIDTH-1:0] I0,
  input  logic             I0_valid,
  output logic             I0_ready,
  input  logic [WIDTH-1:0] I1,
  input  logic             I1_valid,
  output logic             I1_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid0,
  output logic             O_valid1,
  input  logic             O_ready0,
  input  logic             O_ready1,
  output logic             busy
);
  logic [WIDTH-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_tag;
  logic             r_last;
  logic             w_adv;
  logic             w_grant;
  logic             w_any;
  // The whole line moves together; a blocked last stage freezes every stage.
  assign w_adv    = !r_v[DEPTH-1] | (r_tag[DEPTH-1] ? O_ready1 : O_ready0);
  assign w_any    = I0_valid | I1_valid;
  assign w_grant  = (I0_valid & I1_valid) ? !r_last : I1_valid;
  assign I0_ready = w_adv & I0_valid & !w_grant;
  assign I1_ready = w_adv & I1_valid & w_grant;
  assign O        = r_data[DEPTH-1];
  assign O_valid0 = r_v[DEPTH-1] & !r_tag[DEPTH-1];
  assign O_valid1 = r_v[DEPTH-1] & r_tag[DEPTH-1];
  assign busy     = |r_v;
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_v    <= '0;
      r_tag  <= '0;
      r_last <= 1'b1;
      for (int k = 0; k < DEPTH; k++) r_data[k] <= '0;
    end else if (w_adv) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_data[k] <= r_data[k-1];
        r_v[k]    <= r_v[k-1];
        r_tag[k]  <= r_tag[k-1];
      end
      r_data[0] <= w_grant ? I1 : I0;
      r_v[0]    <= w_any;
      r_tag[0]  <= w_grant;
      if (w_any) r_last <= w_grant;
    end
  end
endmodule

// File: tb/tb_shared_delay_arbiter.sv
// tb_shared_delay_arbiter: queue-based model checked every cycle, plus directed literal checks.
module tb_shared_delay_arbiter;
  localparam int W = 4;
  localparam int D = 3;
  logic CLK = 0, ASYNCRESETN = 1;
  logic [W-1:0] I0 = '0, I1 = '0;
  logic I0_valid = 0, I1_valid = 0, O_ready0 = 0, O_ready1 = 0;
  logic I0_ready, I1_ready, O_valid0, O_valid1, busy;
  logic [W-1:0] O;
  int n_vec = 0, n_bad = 0;

  typedef struct packed {logic v; logic t; logic [W-1:0] d;} ent_t;
  ent_t pipe[$];
  bit m_last;

  shared_delay_arbiter #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
    .I0(I0), .I0_valid(I0_valid), .I0_ready(I0_ready),
    .I1(I1), .I1_valid(I1_valid), .I1_ready(I1_ready),
    .O(O), .O_valid0(O_valid0), .O_valid1(O_valid1),
    .O_ready0(O_ready0), .O_ready1(O_ready1), .busy(busy));

  always #5 CLK = ~CLK;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, got, exp);
    end
  endtask

  function automatic bit m_adv();
    ent_t l;
    l = pipe[D-1];
    return !l.v || (l.t ? O_ready1 : O_ready0);
  endfunction

  function automatic bit m_grant();
    if (I0_valid && I1_valid) return !m_last;
    return I1_valid;
  endfunction

  always @(posedge CLK or negedge ASYNCRESETN) begin
    ent_t e;
    if (!ASYNCRESETN) begin
      pipe.delete();
      repeat (D) pipe.push_back('0);
      m_last = 1;
    end else if (pipe.size() == D && m_adv()) begin
      e.v = I0_valid || I1_valid;
      e.t = m_grant();
      e.d = e.t ? I1 : I0;
      void'(pipe.pop_back());
      pipe.push_front(e);
      if (e.v) m_last = e.t;
    end
  end

  always @(negedge CLK) begin
    ent_t l;
    bit any;
    if (pipe.size() == D) begin
      l = pipe[D-1];
      any = 0;
      foreach (pipe[k]) any |= pipe[k].v;
      chk("m_I0_ready", I0_ready, m_adv() && I0_valid && !m_grant());
      chk("m_I1_ready", I1_ready, m_adv() && I1_valid && m_grant());
      chk("m_O_valid0", O_valid0, l.v && !l.t);
      chk("m_O_valid1", O_valid1, l.v && l.t);
      chk("m_busy", busy, any);
      if (l.v) chk("m_O", O, l.d);
    end
  end

  task automatic step(input logic v0, input logic [W-1:0] d0, input logic v1,
                      input logic [W-1:0] d1, input logic r0, input logic r1);
    @(posedge CLK);
    #1;
    I0_valid = v0; I0 = d0; I1_valid = v1; I1 = d1; O_ready0 = r0; O_ready1 = r1;
    @(negedge CLK);
  endtask

  task automatic rst_pulse();
    #1;
    I0_valid = 0; I1_valid = 0; I0 = '0; I1 = '0; O_ready0 = 0; O_ready1 = 0;
    ASYNCRESETN = 0;
    #1;
    chk("rst_O", O, 0);
    chk("rst_O_valid0", O_valid0, 0);
    chk("rst_O_valid1", O_valid1, 0);
    chk("rst_busy", busy, 0);
    #1 ASYNCRESETN = 1;
  endtask

  initial begin
    #1 ASYNCRESETN = 0;
    #20 ASYNCRESETN = 1;
    rst_pulse();
    for (int i = 0; i < 7; i++) begin
      step(i < 3, W'(i + 1), 0, '0, 1, 0);
      if (i < 3) chk("t1_I0_ready", I0_ready, 1);
      if (i >= 3 && i <= 5) begin
        chk("t1_O", O, i - 2);
        chk("t1_O_valid0", O_valid0, 1);
      end
      chk("t1_O_valid1", O_valid1, 0);
    end
    chk("t1_busy_end", busy, 0);
    rst_pulse();
    for (int i = 0; i < 6; i++) begin
      step(1, 4'hA, 1, 4'h5, 1, 1);
      if (i < 4) begin
        chk("t2_I0_ready", I0_ready, i % 2 == 0);
        chk("t2_I1_ready", I1_ready, i % 2 == 1);
      end
      if (i >= 3) begin
        chk("t2_O", O, (i % 2 == 1) ? 4'hA : 4'h5);
        chk("t2_O_valid0", O_valid0, i % 2 == 1);
        chk("t2_O_valid1", O_valid1, i % 2 == 0);
      end
    end
    rst_pulse();
    step(1, 4'h7, 0, '0, 0, 1);
    step(0, '0, 0, '0, 0, 1);
    step(0, '0, 0, '0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'h3, 1, 4'h4, 0, 1);
      chk("t3_O", O, 4'h7);
      chk("t3_O_valid0", O_valid0, 1);
      chk("t3_I0_ready", I0_ready, 0);
      chk("t3_I1_ready", I1_ready, 0);
    end
    step(0, '0, 1, 4'h4, 1, 1);
    chk("t3_resume_I1_ready", I1_ready, 1);
    step(0, '0, 0, '0, 1, 1);
    chk("t3_drained_O_valid0", O_valid0, 0);
    rst_pulse();
    step(0, '0, 1, 4'h9, 1, 0);
    step(0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 0);
    step(1, 4'h2, 0, '0, 1, 0);
    chk("t4_O", O, 4'h9);
    chk("t4_O_valid1", O_valid1, 1);
    chk("t4_O_valid0", O_valid0, 0);
    step(1, 4'h2, 0, '0, 1, 0);
    chk("t4_held_O_valid1", O_valid1, 1);
    chk("t4_stall_I0_ready", I0_ready, 0);
    step(1, 4'h2, 0, '0, 1, 1);
    chk("t4_release_I0_ready", I0_ready, 1);
    step(0, '0, 0, '0, 1, 1);
    chk("t4_gone_O_valid1", O_valid1, 0);
    rst_pulse();
    for (int i = 0; i < 3; i++) step(1, W'(i + 1), 0, '0, 1, 1);
    chk("t5_busy", busy, 1);
    rst_pulse();
    step(1, 4'h1, 1, 4'h2, 1, 1);
    chk("t5_first_I0_ready", I0_ready, 1);
    chk("t5_first_I1_ready", I1_ready, 0);
    rst_pulse();
    step(1, 4'h1, 1, 4'h2, 1, 1);
    chk("t6_g0", I0_ready, 1);
    step(1, 4'h1, 1, 4'h2, 1, 1);
    chk("t6_g1", I1_ready, 1);
    step(0, '0, 1, 4'h3, 1, 1);
    chk("t6_again_I1_ready", I1_ready, 1);
    chk("t6_again_I0_ready", I0_ready, 0);
    for (int i = 0; i < 30; i++)
      step(i[0] | i[2], W'(i), i % 3 != 0, ~W'(i), i % 4 != 3, i % 5 != 2);
    repeat (D + 2) step(0, '0, 0, '0, 1, 1);
    chk("final_busy", busy, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
